// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch stage between the PC and decode.
//
// Takes the PC value, issues in-order requests to instruction memory and
// pulses pcAdvance whenever a request is accepted. Returned words are
// paired with their fetch address in a DEPTH-entry queue that feeds
// decode. A flush (taken branch) empties the queue and discards every
// response still in flight.
//
// Optional feature: define FETCH_BYPASS_EN to forward a response straight
// to decode when the queue is empty (0-cycle latency). Without it the
// response is always registered first (1-cycle latency).
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   readAddress      current PC value
//   pcAdvance        request accepted this cycle; PC steps
//   flush            taken branch: drop queued and in-flight fetches
//   imemReq*         request channel to instruction memory
//   imemResp*        in-order response channel (no back-pressure)
//   instr*           instruction channel to decode
//   dbgState         current FSM state (0 IDLE, 1 RUN, 2 FLUSH)
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. A producer holds valid and its payload stable until the transfer;
// the only exception is flush, which withdraws instrValid.
module fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readAddress,
    output logic              pcAdvance,
    input  logic              flush,
    output logic              imemReqValid,
    input  logic              imemReqReady,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemRespValid,
    input  logic [DATA_W-1:0] imemRespData,
    output logic              instrValid,
    input  logic              instrReady,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instrPC,
    output logic [1:0]        dbgState
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] PONE    = PW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } stateType;

    stateType state, stateNext;

    // Instruction queue and the address FIFO that pairs responses with PCs.
    logic [DATA_W-1:0] qData  [DEPTH];
    logic [ADDR_W-1:0] qPC    [DEPTH];
    logic [ADDR_W-1:0] afAddr [DEPTH];
    logic [PW-1:0]     qHead, qTail, afHead, afTail;
    logic [CW-1:0]     occ, outCnt, discard;

    logic              hasCredit, accept, queueValid;
    logic              pushQ, popQ, bypassValid, bypassTake;
    logic [CW-1:0]     respInc;

    assign respInc    = CW'(imemRespValid);
    assign queueValid = (occ != '0);
    // occ + outCnt never exceeds DEPTH, so the sum fits in CW bits.
    assign hasCredit  = (occ + outCnt) < DEPTH_C;

    assign imemReqValid = (state == RUN) && hasCredit && !flush;
    assign accept       = imemReqValid && imemReqReady;
    assign pcAdvance    = accept;
    assign imemAddr     = readAddress;
    assign dbgState     = state;

`ifdef FETCH_BYPASS_EN
    // Empty queue: present the response directly; it only enters the
    // queue if decode does not take it this cycle.
    assign bypassValid = (state == RUN) && !flush && !queueValid && imemRespValid;
    assign bypassTake  = bypassValid && instrReady;
    assign instrValid  = queueValid || bypassValid;
    assign instr       = bypassValid ? imemRespData   : qData[qHead];
    assign instrPC     = bypassValid ? afAddr[afHead] : qPC[qHead];
`else
    assign bypassValid = 1'b0;
    assign bypassTake  = 1'b0;
    assign instrValid  = queueValid;
    assign instr       = qData[qHead];
    assign instrPC     = qPC[qHead];
`endif

    assign popQ  = queueValid && instrReady && !flush;
    assign pushQ = (state == RUN) && !flush && imemRespValid && !bypassTake;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: stateNext = RUN;
            RUN: begin
                // Responses arriving in the flush cycle are already dropped,
                // so only the remainder must be waited out.
                if (flush && ((outCnt - respInc) != '0)) begin
                    stateNext = FLUSH;
                end
            end
            FLUSH: begin
                if ((discard == '0) || (imemRespValid && (discard == ONE_C))) begin
                    stateNext = RUN;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            qHead   <= '0;
            qTail   <= '0;
            afHead  <= '0;
            afTail  <= '0;
            occ     <= '0;
            outCnt  <= '0;
            discard <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                qData[i]  <= '0;
                qPC[i]    <= '0;
                afAddr[i] <= '0;
            end
        end else begin
            // Address FIFO: every response, kept or dropped, retires one entry.
            if (accept) begin
                afAddr[afTail] <= readAddress;
                afTail         <= afTail + PONE;
            end
            if (imemRespValid) begin
                afHead <= afHead + PONE;
            end
            outCnt <= outCnt + CW'(accept) - respInc;

            if ((state == RUN) && flush) begin
                discard <= outCnt - respInc;
            end else if ((state == FLUSH) && imemRespValid && (discard != '0)) begin
                discard <= discard - ONE_C;
            end

            if (flush) begin
                occ   <= '0;
                qHead <= '0;
                qTail <= '0;
            end else begin
                occ <= occ + CW'(pushQ) - CW'(popQ);
                if (pushQ) begin
                    qData[qTail] <= imemRespData;
                    qPC[qTail]   <= afAddr[afHead];
                    qTail        <= qTail + PONE;
                end
                if (popQ) begin
                    qHead <= qHead + PONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] readAddress;
    logic              pcAdvance;
    logic              flush;
    logic              imemReqValid;
    logic              imemReqReady;
    logic [ADDR_W-1:0] imemAddr;
    logic              imemRespValid;
    logic [DATA_W-1:0] imemRespData;
    logic              instrValid;
    logic              instrReady;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instrPC;
    logic [1:0]        dbgState;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .readAddress(readAddress), .pcAdvance(pcAdvance),
        .flush(flush), .imemReqValid(imemReqValid), .imemReqReady(imemReqReady),
        .imemAddr(imemAddr), .imemRespValid(imemRespValid), .imemRespData(imemRespData),
        .instrValid(instrValid), .instrReady(instrReady), .instr(instr),
        .instrPC(instrPC), .dbgState(dbgState)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stimulus knobs (percent probabilities, memory latency range).
    int latMin = 1, latMax = 1, pReqReady = 100, pInstrReady = 100, pFlush = 0;
    bit forceFlush = 1'b0;
    logic [ADDR_W-1:0] flushTarget = '0;

    // Reference model: PC, outstanding requests (with memory due cycle),
    // expected decode queue, and fetch-stage mode.
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pendAddr[$];
    int                pendDue[$];
    int                lastDue;
    logic [ADDR_W-1:0] expPc[$];
    logic [DATA_W-1:0] expQ[$];
    bit                inIdle;
    int                discardLeft;

    // Observations from the last stepped cycle.
    bit                obsReqValid, obsAdvance, obsValid, obsResp;
    logic [ADDR_W-1:0] obsPC, obsAddr;

    function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic applyReset(input logic [ADDR_W-1:0] startPc);
        reset = 1'b1; flush = 1'b0; imemReqReady = 1'b0; instrReady = 1'b0;
        imemRespValid = 1'b0; imemRespData = '0; readAddress = startPc;
        pendAddr.delete(); pendDue.delete(); expPc.delete(); expQ.delete();
        lastDue = 0; discardLeft = 0; inIdle = 1'b1; pc = startPc;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); cyc++;
            @(negedge clk); #1;
            checkValue("rst_imemReqValid", imemReqValid, 1'b0);
            checkValue("rst_pcAdvance", pcAdvance, 1'b0);
            checkValue("rst_instrValid", instrValid, 1'b0);
            checkValue("rst_instr", instr, '0);
            checkValue("rst_instrPC", instrPC, '0);
            checkValue("rst_state", dbgState, 2'd0);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic stepCycle();
        bit running, respNow, expReq, expBy, expValid, accept, taken;
        int qn, lat, due;
        logic [ADDR_W-1:0] respPc;
        logic [1:0] expState;
        reset         = 1'b0;
        imemReqReady  = ($urandom_range(99) < pReqReady);
        instrReady    = ($urandom_range(99) < pInstrReady);
        flush         = forceFlush || ($urandom_range(99) < pFlush);
        readAddress   = pc;
        respNow       = (pendDue.size() > 0) && (pendDue[0] <= cyc);
        imemRespValid = respNow;
        imemRespData  = respNow ? memWord(pendAddr[0]) : DATA_W'($urandom);
        #1;
        qn       = expQ.size();
        running  = !inIdle && (discardLeft == 0);
        expReq   = running && (qn + pendAddr.size() < DEPTH) && !flush;
        expBy    = BYPASS && running && !flush && (qn == 0) && respNow;
        expValid = (qn > 0) || expBy;
        expState = inIdle ? 2'd0 : ((discardLeft > 0) ? 2'd2 : 2'd1);
        checkValue("imemReqValid", imemReqValid, expReq);
        checkValue("pcAdvance", pcAdvance, expReq && imemReqReady);
        checkValue("imemAddr", imemAddr, pc);
        checkValue("instrValid", instrValid, expValid);
        checkValue("state", dbgState, expState);
        if (expValid) begin
            checkValue("instr", instr, (qn > 0) ? expQ[0] : memWord(pendAddr[0]));
            checkValue("instrPC", instrPC, (qn > 0) ? expPc[0] : pendAddr[0]);
        end
        obsReqValid = imemReqValid; obsAdvance = pcAdvance; obsValid = instrValid;
        obsResp = respNow; obsPC = instrPC; obsAddr = imemAddr;

        accept = expReq && imemReqReady;
        respPc = '0;
        if (respNow) begin
            respPc = pendAddr.pop_front();
            void'(pendDue.pop_front());
        end
        if (inIdle) begin
            inIdle = 1'b0;
        end else if (discardLeft > 0) begin
            if (respNow) discardLeft--;
        end else if (flush) begin
            expPc.delete(); expQ.delete();
            discardLeft = pendAddr.size();
        end else begin
            taken = 1'b0;
            if (qn > 0 && instrReady) begin
                void'(expPc.pop_front()); void'(expQ.pop_front());
            end else if (expBy && instrReady) begin
                taken = 1'b1;
            end
            if (respNow && !taken) begin
                expPc.push_back(respPc); expQ.push_back(memWord(respPc));
            end
        end
        if (accept) begin
            lat = $urandom_range(latMax, latMin);
            due = cyc + lat;
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            pendAddr.push_back(pc); pendDue.push_back(due);
        end
        if (flush) pc = flushTarget;
        else if (accept) pc = pc + 32'd4;
        @(posedge clk); cyc++;
        @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int advCount, firstResp, respSeen, lastRespIdx, firstAdv;
        bit found, validAtResp, validAfter, gotValid;
        logic [ADDR_W-1:0] firstAddr, firstPc;

        // Startup: request valid only from the second cycle.
        applyReset(32'h0);
        stepCycle(); checkValue("startup_cycle1_reqValid", obsReqValid, 1'b0);
        stepCycle(); checkValue("startup_cycle2_reqValid", obsReqValid, 1'b1);

        // Streaming at latency 1 from 0x100.
        applyReset(32'h100);
        stepCycle();
        advCount = 0; firstResp = -1; validAtResp = 0; validAfter = 0; gotValid = 0; firstPc = '0;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            if (obsAdvance) advCount++;
            if (firstResp < 0 && obsResp) begin
                firstResp = i; validAtResp = obsValid;
            end else if (firstResp >= 0 && firstResp == i - 1) begin
                validAfter = obsValid;
            end
            if (!gotValid && obsValid) begin gotValid = 1; firstPc = obsPC; end
        end
        checkValue("stream_advance_count", advCount, 20);
        checkValue("stream_resp_seen", firstResp >= 0, 1'b1);
        checkValue("bypass_same_cycle_valid", validAtResp, BYPASS);
        checkValue("valid_after_resp", validAfter, 1'b1);
        checkValue("stream_first_pc", firstPc, 32'h100);

        // Backpressure: decode stalled, exactly DEPTH accepts.
        applyReset(32'h400);
        pInstrReady = 0;
        stepCycle();
        advCount = 0;
        for (int i = 0; i < 12; i++) begin
            stepCycle();
            if (obsAdvance) advCount++;
        end
        checkValue("backpressure_accepts", advCount, DEPTH);
        checkValue("backpressure_reqValid_low", obsReqValid, 1'b0);
        pInstrReady = 100;
        for (int i = 0; i < 10; i++) stepCycle();

        // Flush with three requests in flight.
        applyReset(32'h300);
        latMin = 4; latMax = 4; found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (!inIdle && discardLeft == 0 && pendAddr.size() == 3 && !(pendDue[0] <= cyc)) begin
                forceFlush = 1; flushTarget = 32'h200; found = 1;
            end
            stepCycle();
            forceFlush = 0;
        end
        checkValue("flush_setup", found, 1'b1);
        respSeen = 0; lastRespIdx = -100; firstAdv = -1; firstAddr = '0;
        for (int i = 0; i < 40 && firstAdv < 0; i++) begin
            stepCycle();
            if (obsResp) begin respSeen++; lastRespIdx = i; end
            if (obsAdvance) begin firstAdv = i; firstAddr = obsAddr; end
        end
        checkValue("flush_dropped", respSeen, 3);
        checkValue("flush_reissue_gap", firstAdv - lastRespIdx, 1);
        checkValue("flush_new_addr", firstAddr, 32'h200);
        gotValid = 0; firstPc = '0;
        for (int i = 0; i < 20 && !gotValid; i++) begin
            stepCycle();
            if (obsValid) begin gotValid = 1; firstPc = obsPC; end
        end
        checkValue("flush_first_instrPC", firstPc, 32'h200);

        // Response, pop and flush in the same cycle.
        applyReset(32'h500);
        latMin = 1; latMax = 1; pInstrReady = 0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (!inIdle && discardLeft == 0 && expQ.size() > 0 && pendDue.size() > 0 && pendDue[0] <= cyc) begin
                forceFlush = 1; flushTarget = 32'h600; pInstrReady = 100; found = 1;
            end
            stepCycle();
            forceFlush = 0;
        end
        checkValue("simul_setup", found, 1'b1);
        pInstrReady = 100;
        stepCycle();
        checkValue("simul_valid_after_flush", obsValid, 1'b0);

        // Randomized traffic with flushes and a mid-run reset.
        applyReset($urandom & ~32'h3);
        latMin = 1; latMax = 5; pReqReady = 70; pInstrReady = 60; pFlush = 4;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) applyReset(32'h1000);
            flushTarget = $urandom & ~32'h3;
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
